// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel LED PWM sequencer: one shared prescaler and frame counter,
// one shadow configuration slot, and per-channel OFF / STEADY / BLINK /
// BREATHE duty generators. Duty values only change on frame boundaries.
module rgb_pwm_sequencer #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 187
) (
    input  logic                clki,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_level,
    input  logic [15:0]         cfg_period,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_end
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam int                  PSC_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0]    PSC_LAST  = PSC_W'(PRESCALE - 1);
    localparam logic [PSC_W-1:0]    PSC_ONE   = PSC_W'(1);
    localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [3:0]          CH_LIM    = 4'(CHANNELS);

    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    logic [PSC_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick_s, bnd_s, accept_s, chan_ok_s;
    logic                frame_end_q;
    logic [CHANNELS-1:0] pwm_q;
    logic                pend_q, pend_d;
    logic                cfg_ready_q;
    logic [2:0]          sh_chan_q;
    mode_e               sh_mode_q;
    logic [PWM_BITS-1:0] sh_level_q;
    logic [15:0]         sh_period_q;
    logic [PWM_BITS-1:0] duty_s [CHANNELS];

    // Reset synchroniser: asserts immediately, releases two clki edges later.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Timebase, frame boundary detection and shadow-slot occupancy.
    always_comb begin
        tick_s    = (presc_q == PSC_LAST);
        presc_d   = tick_s ? {PSC_W{1'b0}} : (presc_q + PSC_ONE);
        pwm_cnt_d = tick_s ? (pwm_cnt_q + DUTY_ONE) : pwm_cnt_q;
        bnd_s     = tick_s && (pwm_cnt_q == CNT_MAX);
        accept_s  = cfg_valid && cfg_ready_q;
        chan_ok_s = ({1'b0, cfg_chan} < CH_LIM);
        pend_d    = pend_q;
        if (pend_q) begin
            pend_d = !bnd_s;
        end else if (accept_s && chan_ok_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = 1'b0;
        end
    end

    // Shared counters, frame_end pulse, handshake and shadow capture.
    always_ff @(posedge clki or negedge rst_int_n) begin
        if (!rst_int_n) begin
            presc_q     <= {PSC_W{1'b0}};
            pwm_cnt_q   <= DUTY_ZERO;
            frame_end_q <= 1'b0;
            pend_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            sh_chan_q   <= 3'd0;
            sh_mode_q   <= MODE_OFF;
            sh_level_q  <= DUTY_ZERO;
            sh_period_q <= 16'd1;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            frame_end_q <= bnd_s;
            pend_q      <= pend_d;
            cfg_ready_q <= !pend_d;
            if (accept_s && chan_ok_s) begin
                sh_chan_q   <= cfg_chan;
                sh_mode_q   <= mode_e'(cfg_mode);
                sh_level_q  <= cfg_level;
                sh_period_q <= (cfg_period == 16'd0) ? 16'd1 : cfg_period;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        mode_e               mode_q, mode_d;
        logic [PWM_BITS-1:0] level_q, level_d;
        logic [PWM_BITS-1:0] bduty_q, bduty_d;
        logic [PWM_BITS-1:0] duty_q, duty_d;
        logic [15:0]         period_q, period_d;
        logic [15:0]         fcnt_q, fcnt_d;
        logic                phase_q, phase_d;
        logic                dir_q, dir_d;
        logic                apply_s, ev_s;

        // Per-frame update: apply the shadow slot or advance blink/breathe state.
        always_comb begin
            mode_d   = mode_q;
            level_d  = level_q;
            period_d = period_q;
            fcnt_d   = fcnt_q;
            phase_d  = phase_q;
            bduty_d  = bduty_q;
            dir_d    = dir_q;
            duty_d   = duty_q;
            ev_s     = 1'b0;
            apply_s  = pend_q && (sh_chan_q == 3'(g));
            if (bnd_s) begin
                if (apply_s) begin
                    mode_d   = sh_mode_q;
                    level_d  = sh_level_q;
                    period_d = sh_period_q;
                    fcnt_d   = 16'd0;
                    phase_d  = 1'b1;
                    bduty_d  = DUTY_ZERO;
                    dir_d    = 1'b0;
                end else begin
                    if (fcnt_q == (period_q - 16'd1)) begin
                        fcnt_d = 16'd0;
                        ev_s   = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + 16'd1;
                        ev_s   = 1'b0;
                    end
                    if (ev_s) begin
                        phase_d = ~phase_q;
                        if (mode_q != MODE_BREATHE) begin
                            bduty_d = bduty_q;
                        end else if (level_q == DUTY_ZERO) begin
                            bduty_d = DUTY_ZERO;
                        end else if (!dir_q) begin
                            bduty_d = bduty_q + DUTY_ONE;
                            dir_d   = ((bduty_q + DUTY_ONE) == level_q);
                        end else begin
                            bduty_d = bduty_q - DUTY_ONE;
                            dir_d   = !(bduty_q == DUTY_ONE);
                        end
                    end else begin
                        phase_d = phase_q;
                    end
                end
                case (mode_d)
                    MODE_OFF:     duty_d = DUTY_ZERO;
                    MODE_STEADY:  duty_d = level_d;
                    MODE_BLINK:   duty_d = phase_d ? level_d : DUTY_ZERO;
                    MODE_BREATHE: duty_d = bduty_d;
                    default:      duty_d = DUTY_ZERO;
                endcase
            end else begin
                duty_d = duty_q;
            end
        end

        // Per-channel state registers.
        always_ff @(posedge clki or negedge rst_int_n) begin
            if (!rst_int_n) begin
                mode_q   <= MODE_OFF;
                level_q  <= DUTY_ZERO;
                period_q <= 16'd1;
                fcnt_q   <= 16'd0;
                phase_q  <= 1'b1;
                bduty_q  <= DUTY_ZERO;
                dir_q    <= 1'b0;
                duty_q   <= DUTY_ZERO;
            end else begin
                mode_q   <= mode_d;
                level_q  <= level_d;
                period_q <= period_d;
                fcnt_q   <= fcnt_d;
                phase_q  <= phase_d;
                bduty_q  <= bduty_d;
                dir_q    <= dir_d;
                duty_q   <= duty_d;
            end
        end

        assign duty_s[g] = duty_q;
    end

    // Registered PWM comparators.
    always_ff @(posedge clki or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pwm_q <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_q[i] <= (pwm_cnt_q < duty_s[i]);
            end
        end
    end

    assign pwm_out   = pwm_q;
    assign frame_end = frame_end_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Scoreboard bench: the driver issues configs at frame boundaries and pushes
// the per-frame duty each channel should show; the monitor measures high
// cycles per frame window and compares.
module tb_rgb_pwm_sequencer;

    localparam int NCH = 3;

    typedef struct packed {
        logic [2:0]  ch;
        logic [1:0]  mode;
        logic [3:0]  level;
        logic [15:0] period;
    } cfg_t;

    logic           clki = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [2:0]     cfg_chan = 3'd0;
    logic [1:0]     cfg_mode = 2'd0;
    logic [3:0]     cfg_level = 4'd0;
    logic [15:0]    cfg_period = 16'd0;
    logic [NCH-1:0] pwm_out;
    logic           frame_end;

    int total = 0;
    int bad   = 0;

    // reference model: config plus frames elapsed since apply
    int m_mode [NCH];
    int m_level[NCH];
    int m_per  [NCH];
    int m_n    [NCH];
    logic [11:0] exp_q[$];

    rgb_pwm_sequencer #(.CHANNELS(NCH), .PWM_BITS(4), .PRESCALE(1)) dut (
        .clki(clki), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
        .cfg_period(cfg_period), .pwm_out(pwm_out), .frame_end(frame_end)
    );

    always #5 clki = ~clki;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic cfg_t mk(input int ch, input int mode, input int lvl, input int per);
        cfg_t c;
        c.ch = 3'(ch); c.mode = 2'(mode); c.level = 4'(lvl); c.period = 16'(per);
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        return mk($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 3));
    endfunction

    // Duty a channel shows in its current frame, from the mode rules.
    function automatic int duty_of(input int ch);
        int steps, t, l;
        l = m_level[ch];
        steps = m_n[ch] / m_per[ch];
        case (m_mode[ch])
            1: return l;
            2: return ((steps % 2) == 0) ? l : 0;
            3: begin
                if (l == 0) return 0;
                t = steps % (2 * l);
                return (t <= l) ? t : (2 * l - t);
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [11:0] model_vec();
        logic [11:0] v;
        v = 12'd0;
        for (int i = 0; i < NCH; i++) v[4*i +: 4] = 4'(duty_of(i));
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = 0; m_level[i] = 0; m_per[i] = 1; m_n[i] = 0;
        end
        exp_q.push_back(12'd0);
        exp_q.push_back(12'd0);
    endtask

    task automatic wait_fe();
        for (int i = 0; i < 64; i++) begin
            @(negedge clki);
            if (frame_end === 1'b1) return;
        end
        chk("frame_end_timeout", 0, 1);
    endtask

    task automatic drive(input cfg_t c);
        cfg_valid = 1'b1; cfg_chan = c.ch; cfg_mode = c.mode;
        cfg_level = c.level; cfg_period = c.period;
    endtask

    // One frame: optionally issue a config at the boundary and predict two frames ahead.
    task automatic frame_step(input bit iss, input cfg_t c, input bit hold, input cfg_t nxt);
        bit ok;
        wait_fe();
        chk("ready_at_frame_end", int'(cfg_ready), 1);
        ok = iss && (c.ch < 3'd3);
        if (iss) drive(c);
        else cfg_valid = 1'b0;
        for (int i = 0; i < NCH; i++) m_n[i]++;
        if (ok) begin
            m_mode[c.ch]  = int'(c.mode);
            m_level[c.ch] = int'(c.level);
            m_per[c.ch]   = (c.period == 16'd0) ? 1 : int'(c.period);
            m_n[c.ch]     = 0;
        end
        exp_q.push_back(model_vec());
        @(negedge clki);
        chk("ready_after_accept", int'(cfg_ready), ok ? 0 : 1);
        if (hold) drive(nxt);
        else cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) frame_step(1'b0, 28'd0, 1'b0, 28'd0);
    endtask

    // Monitor: measure each frame window and compare with the scoreboard.
    int  hi[NCH];
    int  len;
    bit  first;
    always @(negedge clki) begin
        logic [11:0] e;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < NCH; i++) hi[i] = 0;
            len = 0;
            first = 1'b1;
        end else begin
            len++;
            for (int i = 0; i < NCH; i++) if (pwm_out[i] === 1'b1) hi[i]++;
            if (frame_end === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < NCH; i++)
                        chk($sformatf("duty_ch%0d", i), hi[i], int'(e[4*i +: 4]));
                end
                if (!first) chk("frame_length", len, 16);
                first = 1'b0;
                len = 0;
                for (int i = 0; i < NCH; i++) hi[i] = 0;
            end
        end
    end

    initial begin
        cfg_t cur, nxt;
        bit iss, hold, carry;
        repeat (3) @(negedge clki);
        chk("reset_pwm_out", int'(pwm_out), 0);
        chk("reset_frame_end", int'(frame_end), 0);
        chk("reset_cfg_ready", int'(cfg_ready), 1);
        @(posedge clki); #2;
        model_reset();
        rst_n = 1'b1;

        idle(3);
        frame_step(1'b1, mk(0, 1, 4, 1), 1'b0, 28'd0);
        idle(3);
        frame_step(1'b1, mk(1, 2, 15, 2), 1'b0, 28'd0);
        idle(6);
        frame_step(1'b1, mk(2, 3, 3, 1), 1'b0, 28'd0);
        idle(8);
        frame_step(1'b1, mk(5, 1, 15, 1), 1'b0, 28'd0);
        idle(2);
        frame_step(1'b1, mk(0, 1, 7, 1), 1'b1, mk(1, 1, 2, 1));
        frame_step(1'b1, mk(1, 1, 2, 1), 1'b0, 28'd0);
        idle(2);
        frame_step(1'b1, mk(2, 3, 0, 0), 1'b0, 28'd0);
        idle(3);

        carry = 1'b0;
        for (int f = 0; f < 40; f++) begin
            if (carry) begin
                iss = 1'b1; cur = nxt;
            end else begin
                iss = ($urandom_range(0, 2) != 0); cur = rand_cfg();
            end
            nxt = rand_cfg();
            hold = iss && (cur.ch < 3'd3) && ($urandom_range(0, 3) == 0) && (f < 39);
            frame_step(iss, cur, hold, nxt);
            carry = hold;
        end

        // asynchronous reset mid-frame with a config pending
        frame_step(1'b1, mk(0, 1, 8, 1), 1'b0, 28'd0);
        idle(1);
        wait_fe();
        drive(mk(1, 1, 9, 1));
        @(negedge clki);
        chk("ready_pending_before_reset", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        @(negedge clki);
        chk("ch0_high_before_reset", int'(pwm_out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_pwm_out", int'(pwm_out), 0);
        chk("async_reset_frame_end", int'(frame_end), 0);
        chk("async_reset_cfg_ready", int'(cfg_ready), 1);
        repeat (3) @(negedge clki);
        @(posedge clki); #2;
        model_reset();
        rst_n = 1'b1;
        #1 chk("ready_after_release", int'(cfg_ready), 1);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
